triangle_setup: RTL

- Sits directly downstream of the register file and consumes its one-cycle `tri_valid` pulse plus the latched triangle vertices.
- Computes three edge-function coefficient sets (A, B, C) and a screen-clamped pixel bounding box, using one shared 16x16 multiplier over six cycles.
- Presents the result to the rasterizer on a valid/ready handshake.
- The register file has no backpressure, so this block holds one input skid entry, reports `busy` (ORed into `gpu_busy`) and flags a sticky overflow when a triangle is lost.

---
 rtl/gpu_pkg.sv | 76 +++++++
 rtl/setup_mul16.sv | 21 ++
 rtl/triangle_setup.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpu_pkg
// Purpose  : Shared types, screen defaults and small helpers for triangle setup.
// Revision : 1.0 - initial release
// ============================================================================
package gpu_pkg;

  localparam int SCREEN_W_DEFAULT = 640;
  localparam int SCREEN_H_DEFAULT = 480;
  localparam logic [2:0] MUL_LAST = 3'd5;

  typedef struct packed {
    logic [16:0] a;
    logic [16:0] b;
    logic [32:0] c;
  } edge_coef_t;

  typedef struct packed {
    logic [9:0] min_x;
    logic [9:0] max_x;
    logic [9:0] min_y;
    logic [9:0] max_y;
  } bbox_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MUL  = 3'd2,
    ST_BBOX = 3'd3,
    ST_EMIT = 3'd4
  } state_t;

  function automatic logic [11:0] min3(input logic [11:0] a, input logic [11:0] b,
                                       input logic [11:0] c);
    logic [11:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [11:0] max3(input logic [11:0] a, input logic [11:0] b,
                                       input logic [11:0] c);
    logic [11:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic [9:0] clamp10(input logic [11:0] v, input logic [11:0] lim);
    logic [11:0] r;
    r = (v > lim) ? lim : v;
    return r[9:0];
  endfunction

  function automatic logic [16:0] sub17(input logic [15:0] a, input logic [15:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  function automatic logic [32:0] sub33(input logic [31:0] a, input logic [31:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  // Product k is x[pair[3:2]] * y[pair[1:0]]; even/odd pairs form one edge's C.
  function automatic logic [3:0] prod_pair(input logic [2:0] k);
    case (k)
      3'd0:    return {2'd0, 2'd1};
      3'd1:    return {2'd1, 2'd0};
      3'd2:    return {2'd1, 2'd2};
      3'd3:    return {2'd2, 2'd1};
      3'd4:    return {2'd2, 2'd0};
      3'd5:    return {2'd0, 2'd2};
      default: return {2'd0, 2'd0};
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/setup_mul16.sv
`default_nettype none
// ============================================================================
// Module   : setup_mul16
// Purpose  : Registered 16x16 unsigned multiplier, one cycle of latency.
// Revision : 1.0 - initial release
// ============================================================================
module setup_mul16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p <= '0;
    else        p <= a * b;
  end

endmodule
`default_nettype wire

// File: rtl/triangle_setup.sv
`default_nettype none
// ============================================================================
// Module   : triangle_setup
// Purpose  : Edge-function coefficients and clamped bbox per triangle, with a
//            one-entry input skid buffer and a shared multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module triangle_setup
  import gpu_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEFAULT,
  parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tri_valid,
  input  logic [2:0][15:0] tri_x,
  input  logic [2:0][15:0] tri_y,
  input  logic [2:0][24:0] tri_z,
  input  logic [2:0][31:0] tri_color,
  input  logic [15:0]      tri_inv_area,
  output logic             setup_valid,
  input  logic             setup_ready,
  output logic [2:0][16:0] edge_a,
  output logic [2:0][16:0] edge_b,
  output logic [2:0][32:0] edge_c,
  output logic [9:0]       bbox_min_x,
  output logic [9:0]       bbox_max_x,
  output logic [9:0]       bbox_min_y,
  output logic [9:0]       bbox_max_y,
  output logic [2:0][24:0] out_z,
  output logic [2:0][31:0] out_color,
  output logic [15:0]      out_inv_area,
  output logic             busy,
  output logic             overflow,
  input  logic             overflow_clr
);

  localparam logic [11:0] MAX_X = 12'(SCREEN_W - 1);
  localparam logic [11:0] MAX_Y = 12'(SCREEN_H - 1);

  state_t state, state_nxt;

  logic             buf_full;
  logic             buf_free;
  logic [2:0][15:0] buf_x, buf_y;
  logic [2:0][24:0] buf_z;
  logic [2:0][31:0] buf_color;
  logic [15:0]      buf_inv;

  logic [2:0][15:0] wx, wy;
  logic [2:0]       cnt;
  logic [4:0][31:0] prod;
  edge_coef_t [2:0] coef;
  bbox_t            bbox;
  logic [11:0]      raw_min_x, raw_max_x, raw_min_y, raw_max_y;
  logic             cull;

  logic [2:0]  mul_idx;
  logic [3:0]  pair;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_p;

  // The buffer drains on the IDLE->LOAD edge, so a new pulse that edge is kept.
  assign buf_free = (state == ST_IDLE) && buf_full;
  assign cull     = (raw_min_x > MAX_X) || (raw_min_y > MAX_Y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full  <= 1'b0;
      buf_x     <= '0;
      buf_y     <= '0;
      buf_z     <= '0;
      buf_color <= '0;
      buf_inv   <= '0;
      overflow  <= 1'b0;
    end else begin
      if (tri_valid && (!buf_full || buf_free)) begin
        buf_full  <= 1'b1;
        buf_x     <= tri_x;
        buf_y     <= tri_y;
        buf_z     <= tri_z;
        buf_color <= tri_color;
        buf_inv   <= tri_inv_area;
      end else if (buf_free) begin
        buf_full <= 1'b0;
      end
      if (tri_valid && buf_full && !buf_free) overflow <= 1'b1;
      else if (overflow_clr)                  overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (buf_full) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_MUL;
      ST_MUL:  if (cnt == MUL_LAST) state_nxt = ST_BBOX;
      ST_BBOX: state_nxt = cull ? ST_IDLE : ST_EMIT;
      ST_EMIT: if (setup_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    setup_valid = (state == ST_EMIT);
    busy        = buf_full || (state != ST_IDLE);
  end

  // Product k is issued one cycle ahead of the MUL slot that stores it.
  always_comb begin
    mul_idx = (state == ST_LOAD) ? 3'd0 : cnt + 3'd1;
    pair    = prod_pair(mul_idx);
    mul_a   = wx[pair[3:2]];
    mul_b   = wy[pair[1:0]];
  end

  setup_mul16 u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (mul_a),
    .b     (mul_b),
    .p     (mul_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wx           <= '0;
      wy           <= '0;
      cnt          <= '0;
      prod         <= '0;
      coef         <= '0;
      bbox         <= '0;
      raw_min_x    <= '0;
      raw_max_x    <= '0;
      raw_min_y    <= '0;
      raw_max_y    <= '0;
      out_z        <= '0;
      out_color    <= '0;
      out_inv_area <= '0;
    end else begin
      if (buf_free) begin
        wx           <= buf_x;
        wy           <= buf_y;
        out_z        <= buf_z;
        out_color    <= buf_color;
        out_inv_area <= buf_inv;
      end
      case (state)
        ST_LOAD: begin
          cnt       <= '0;
          coef[0].a <= sub17(wy[0], wy[1]);
          coef[0].b <= sub17(wx[1], wx[0]);
          coef[1].a <= sub17(wy[1], wy[2]);
          coef[1].b <= sub17(wx[2], wx[1]);
          coef[2].a <= sub17(wy[2], wy[0]);
          coef[2].b <= sub17(wx[0], wx[2]);
          raw_min_x <= min3(wx[0][15:4], wx[1][15:4], wx[2][15:4]);
          raw_max_x <= max3(wx[0][15:4], wx[1][15:4], wx[2][15:4]);
          raw_min_y <= min3(wy[0][15:4], wy[1][15:4], wy[2][15:4]);
          raw_max_y <= max3(wy[0][15:4], wy[1][15:4], wy[2][15:4]);
        end
        ST_MUL: begin
          cnt <= cnt + 3'd1;
          if (cnt == MUL_LAST) begin
            coef[0].c <= sub33(prod[0], prod[1]);
            coef[1].c <= sub33(prod[2], prod[3]);
            coef[2].c <= sub33(prod[4], mul_p);
          end else begin
            prod[cnt] <= mul_p;
          end
        end
        ST_BBOX: begin
          bbox.min_x <= raw_min_x[9:0];
          bbox.max_x <= clamp10(raw_max_x, MAX_X);
          bbox.min_y <= raw_min_y[9:0];
          bbox.max_y <= clamp10(raw_max_y, MAX_Y);
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_edge
    assign edge_a[i] = coef[i].a;
    assign edge_b[i] = coef[i].b;
    assign edge_c[i] = coef[i].c;
  end

  assign bbox_min_x = bbox.min_x;
  assign bbox_max_x = bbox.max_x;
  assign bbox_min_y = bbox.min_y;
  assign bbox_max_y = bbox.max_y;

endmodule
`default_nettype wire
